// File: rtl/ps2_joy_mapper.sv
// PS/2 keyboard to joystick mapper: programmable 8-entry key map feeding one pad for the
// currently selected player, with opposing-direction cleaning and per-button turbo.
module ps2_joy_mapper #(
    parameter int NUM_PLAYERS = 4,
    parameter int TURBO_DIV   = 500000,
    parameter int SOCD_MODE   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [10:0]              ps2_key,
    input  logic                     map_we,
    input  logic [2:0]               map_idx,
    input  logic [8:0]               map_key,
    input  logic [7:0]               turbo_en,
    output logic [8*NUM_PLAYERS-1:0] joystick,
    output logic [1:0]               active_player
);
    localparam int CNT_W = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TURBO_DIV - 1);
    localparam logic [2:0] NP_L = 3'(NUM_PLAYERS);

    logic                     old_stb_r;
    logic [7:0]               held_r;
    logic [8:0]               map_r [0:7];
    logic [1:0]               active_player_r;
    logic [CNT_W-1:0]         turbo_cnt_r;
    logic                     turbo_phase_r;
    logic                     last_ud_r;   // 1: down was pressed more recently than up
    logic                     last_lr_r;   // 1: right was pressed more recently than left
    logic [8*NUM_PLAYERS-1:0] joystick_r;

    logic                     event_s;
    logic                     is_sel_s;
    logic [1:0]               sel_idx_s;
    logic                     sel_ok_s;
    logic [7:0]               match_s;
    logic [7:0]               cleaned_s;
    logic [7:0]               byte_s;
    logic [8*NUM_PLAYERS-1:0] out_s;

    function automatic logic [8:0] map_default(input logic [2:0] idx);
        case (idx)
            3'd0:    map_default = {1'b0, 8'h29};
            3'd1:    map_default = {1'b0, 8'h11};
            3'd2:    map_default = {1'b0, 8'h0D};
            3'd3:    map_default = {1'b0, 8'h5A};
            3'd4:    map_default = {1'b1, 8'h75};
            3'd5:    map_default = {1'b1, 8'h72};
            3'd6:    map_default = {1'b1, 8'h6B};
            default: map_default = {1'b1, 8'h74};
        endcase
    endfunction

    // Event detection, player-select decode and key-map matching against the current table
    always_comb begin
        event_s   = ps2_key[10] ^ old_stb_r;
        is_sel_s  = 1'b0;
        sel_idx_s = 2'd0;
        if (!ps2_key[8]) begin
            case (ps2_key[7:0])
                8'h16:   begin is_sel_s = 1'b1; sel_idx_s = 2'd0; end
                8'h1E:   begin is_sel_s = 1'b1; sel_idx_s = 2'd1; end
                8'h26:   begin is_sel_s = 1'b1; sel_idx_s = 2'd2; end
                8'h25:   begin is_sel_s = 1'b1; sel_idx_s = 2'd3; end
                default: begin is_sel_s = 1'b0; sel_idx_s = 2'd0; end
            endcase
        end else begin
            is_sel_s  = 1'b0;
            sel_idx_s = 2'd0;
        end
        sel_ok_s = event_s & is_sel_s & ps2_key[9] & ({1'b0, sel_idx_s} < NP_L)
                   & (sel_idx_s != active_player_r);
        for (int i = 0; i < 8; i++) begin
            match_s[i] = event_s & ~is_sel_s & (map_r[i] == ps2_key[8:0]);
        end
    end

    // Opposing-direction cleaning, turbo gating and placement into the active player's slice
    always_comb begin
        cleaned_s = held_r;
        if (held_r[4] && held_r[5]) begin
            if (SOCD_MODE == 1) begin
                cleaned_s[4] = ~last_ud_r;
                cleaned_s[5] = last_ud_r;
            end else begin
                cleaned_s[5:4] = 2'b00;
            end
        end else begin
            cleaned_s[5:4] = held_r[5:4];
        end
        if (held_r[6] && held_r[7]) begin
            if (SOCD_MODE == 1) begin
                cleaned_s[6] = ~last_lr_r;
                cleaned_s[7] = last_lr_r;
            end else begin
                cleaned_s[7:6] = 2'b00;
            end
        end else begin
            cleaned_s[7:6] = held_r[7:6];
        end
        byte_s = cleaned_s & (~turbo_en | {8{turbo_phase_r}});
        out_s  = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            out_s[8*p +: 8] = (active_player_r == 2'(p)) ? byte_s : 8'd0;
        end
    end

    // Held buttons, key map, player select, turbo timebase and the output registers
    always_ff @(posedge clk) begin
        old_stb_r <= ps2_key[10];
        if (reset) begin
            held_r          <= 8'd0;
            active_player_r <= 2'd0;
            turbo_cnt_r     <= '0;
            turbo_phase_r   <= 1'b1;
            last_ud_r       <= 1'b0;
            last_lr_r       <= 1'b0;
            joystick_r      <= '0;
            for (int i = 0; i < 8; i++) begin
                map_r[i] <= map_default(3'(i));
            end
        end else begin
            joystick_r <= out_s;
            if (turbo_cnt_r == CNT_MAX) begin
                turbo_cnt_r   <= '0;
                turbo_phase_r <= ~turbo_phase_r;
            end else begin
                turbo_cnt_r <= turbo_cnt_r + CNT_W'(1);
            end
            if (sel_ok_s) begin
                active_player_r <= sel_idx_s;
                held_r          <= 8'd0;
            end else begin
                held_r <= (held_r & ~match_s) | (match_s & {8{ps2_key[9]}});
            end
            if (ps2_key[9] && match_s[5]) begin
                last_ud_r <= 1'b1;
            end else if (ps2_key[9] && match_s[4]) begin
                last_ud_r <= 1'b0;
            end
            if (ps2_key[9] && match_s[7]) begin
                last_lr_r <= 1'b1;
            end else if (ps2_key[9] && match_s[6]) begin
                last_lr_r <= 1'b0;
            end
            if (map_we) begin
                map_r[map_idx] <= map_key;
            end
        end
    end

    assign joystick      = joystick_r;
    assign active_player = active_player_r;

endmodule
